// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: fetch state encoding and address/data width constants.
package mips_pkg;

    localparam int INSTR_BYTES = 4;
    localparam int ADDR_W      = 28;
    localparam int DATA_W      = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_out_reg.sv
// Valid/ready output register between fetch and decode; flush drops the held word.
module fetch_out_reg
    import mips_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W,
    parameter int DATA_WIDTH = DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  capture_i,
    input  logic                  ready_i,
    input  logic [DATA_WIDTH-1:0] instr_i,
    input  logic [ADDR_WIDTH-1:0] pc_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0] pc_o
);

    logic                  valid_d, valid_q;
    logic [DATA_WIDTH-1:0] instr_d, instr_q;
    logic [ADDR_WIDTH-1:0] pc_d,    pc_q;

    // Flush wins; a consumed word without a refill leaves the stage empty.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (capture_i) begin
            valid_d = 1'b1;
            instr_d = instr_i;
            pc_d    = pc_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Output stage state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: PC, IDLE/FETCH/HALT control, redirect and end-of-program halt.
// Optional instruction counter on fetch_count when IMEM_FETCH_CNT_EN is defined.
module imem_fetch_ctrl
    import mips_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W,
    parameter int DATA_WIDTH = DATA_W,
    parameter int MEM_BYTES  = 372,
    parameter int RESET_PC   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic                  halted
`ifdef IMEM_FETCH_CNT_EN
    ,
    output logic [31:0]           fetch_count
`endif
);

    localparam logic [ADDR_WIDTH-1:0] LAST_FETCH = ADDR_WIDTH'(MEM_BYTES - INSTR_BYTES);
    localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(INSTR_BYTES);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(INSTR_BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] PC_INIT    = ADDR_WIDTH'(RESET_PC);

    fetch_state_e          state_d, state_q;
    logic [ADDR_WIDTH-1:0] pc_d,    pc_q;
    logic                  halted_d, halted_q;
    logic                  load_s;
    logic                  capture_s;
    logic                  flush_s;
    logic                  out_valid_s;

    assign load_s = !out_valid_s || out_ready;

    // Next-state: redirect overrides every state and word-aligns the target.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        halted_d  = halted_q;
        capture_s = 1'b0;
        flush_s   = 1'b0;
        if (redirect_valid) begin
            pc_d     = redirect_pc & ALIGN_MASK;
            state_d  = FETCH;
            halted_d = 1'b0;
            flush_s  = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = FETCH;
                    end else begin
                        state_d = IDLE;
                    end
                end
                FETCH: begin
                    if (load_s && (pc_q <= LAST_FETCH)) begin
                        capture_s = 1'b1;
                        pc_d      = pc_q + PC_STEP;
                    end else if (load_s) begin
                        state_d  = HALT;
                        halted_d = 1'b1;
                    end else begin
                        state_d = FETCH;
                    end
                end
                HALT: begin
                    state_d = HALT;
                end
                default: begin
                    state_d  = IDLE;
                    pc_d     = PC_INIT;
                    halted_d = 1'b0;
                end
            endcase
        end
    end

    // Control FSM, program counter and halt flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= PC_INIT;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            halted_q <= halted_d;
        end
    end

    fetch_out_reg #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .flush_i   (flush_s),
        .capture_i (capture_s),
        .ready_i   (out_ready),
        .instr_i   (imem_data),
        .pc_i      (pc_q),
        .valid_o   (out_valid_s),
        .instr_o   (out_instr),
        .pc_o      (out_pc)
    );

`ifdef IMEM_FETCH_CNT_EN
    logic [31:0] cnt_d, cnt_q;

    // A transfer coinciding with a redirect still counts; redirect never clears the count.
    always_comb begin
        if (out_valid_s && out_ready) begin
            cnt_d = cnt_q + 32'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Handed-off instruction counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign fetch_count = cnt_q;
`endif

    assign imem_addr = pc_q;
    assign out_valid = out_valid_s;
    assign halted    = halted_q;

endmodule
